// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues word reads to a 1-cycle instruction memory, buffers
// {inst, pc} in a DEPTH-entry FIFO for decode, and flushes on redirect. IPQ_BYPASS_EN enables an empty-FIFO bypass.
module inst_prefetch_queue #(
    parameter int                  DEPTH      = 4,
    parameter int                  PC_WIDTH   = 30,
    parameter int                  INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = {PC_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_en,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  jump_en,
    input  logic [PC_WIDTH-1:0]   jump_target,
    output logic                  dec_valid,
    output logic [INST_WIDTH-1:0] dec_inst,
    output logic [PC_WIDTH-1:0]   dec_pc,
    input  logic                  dec_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [PC_WIDTH-1:0]   fetch_pc_r;
    logic [PC_WIDTH-1:0]   inflight_pc_r;
    logic                  inflight_r;
    logic [INST_WIDTH-1:0] inst_mem_r [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem_r   [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  bypass_s;
    logic                  pop_s;
    logic                  fifo_pop_s;
    logic                  push_s;
    logic                  credit_s;
    logic [OCC_W-1:0]      occ_s;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Decode-side presentation: FIFO head, or the returning word when bypass applies.
    always_comb begin
        bypass_s = 1'b0;
`ifdef IPQ_BYPASS_EN
        bypass_s = inflight_r && (count_r == {CNT_W{1'b0}});
`endif
        if (bypass_s) begin
            dec_valid = 1'b1;
            dec_inst  = imem_rdata;
            dec_pc    = inflight_pc_r;
        end else begin
            dec_valid = (count_r != {CNT_W{1'b0}});
            dec_inst  = inst_mem_r[rd_ptr_r];
            dec_pc    = pc_mem_r[rd_ptr_r];
        end
    end

    // Handshake, push/pop qualification and request credit.
    always_comb begin
        pop_s      = dec_valid && dec_ready && !jump_en;
        fifo_pop_s = pop_s && !bypass_s;
        // A bypassed word that decode takes this cycle never enters the FIFO.
        push_s     = inflight_r && !jump_en && !(bypass_s && dec_ready);
        occ_s      = OCC_W'(count_r) + OCC_W'(inflight_r) - OCC_W'(pop_s);
        credit_s   = (occ_s < OCC_W'(DEPTH));
        if (reset) begin
            imem_en   = 1'b0;
            imem_addr = fetch_pc_r;
        end else if (jump_en) begin
            imem_en   = 1'b1;
            imem_addr = jump_target;
        end else begin
            imem_en   = credit_s;
            imem_addr = fetch_pc_r;
        end
    end

    // Fetch PC, in-flight tracking and FIFO storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {PC_WIDTH{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_r[i] <= {INST_WIDTH{1'b0}};
                pc_mem_r[i]   <= {PC_WIDTH{1'b0}};
            end
        end else if (jump_en) begin
            fetch_pc_r    <= jump_target + PC_WIDTH'(1);
            inflight_r    <= 1'b1;
            inflight_pc_r <= jump_target;
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else begin
            if (imem_en) begin
                fetch_pc_r    <= fetch_pc_r + PC_WIDTH'(1);
                inflight_r    <= 1'b1;
                inflight_pc_r <= fetch_pc_r;
            end else begin
                inflight_r    <= 1'b0;
            end
            if (push_s) begin
                inst_mem_r[wr_ptr_r] <= imem_rdata;
                pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r             <= wr_ptr_r;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, fifo_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: queue-level reference model plus directed scenarios.
module tb_inst_prefetch_queue;

    localparam int DEPTH = 4;
    localparam logic [29:0] RST_PC = 30'h100;
`ifdef IPQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset, imem_en, jump_en, dec_valid, dec_ready;
    logic [29:0] imem_addr, jump_target, dec_pc;
    logic [31:0] imem_rdata, dec_inst;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct { logic [29:0] pc; int c; } req_t;
    req_t        q[$];
    logic [29:0] nxt;
    logic [29:0] acc_pc[$];
    int          acc_cyc[$];
    int          req_cnt = 0;

    inst_prefetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(30), .INST_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .jump_en(jump_en), .jump_target(jump_target),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h5A5A_0000;
    endfunction

    // Instruction memory with 1-cycle latency; garbage when not read.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= inst_of(imem_addr);
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [29:0] exp);
        if (idx < acc_pc.size()) chk(name, {2'b00, acc_pc[idx]}, {2'b00, exp});
        else begin
            n_cmp++; n_fail++;
            $display("FAIL %s: only %0d accepted, required index %0d", name, acc_pc.size(), idx);
        end
    endtask

    task automatic chk_acc_cyc(input string name, input int idx, input int base, input int delta);
        if (idx < acc_cyc.size()) chk(name, acc_cyc[idx] - base, delta);
        else begin
            n_cmp++; n_fail++;
            $display("FAIL %s: only %0d accepted, required index %0d", name, acc_cyc.size(), idx);
        end
    endtask

    // Reference model: outstanding requests since the last flush, in order, with issue cycle.
    always @(negedge clk) begin
        logic exp_v;
        if (reset) begin
            chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
            q.delete();
            nxt = RST_PC;
        end else begin
            exp_v = (q.size() > 0) && (q[0].c <= cyc - LAT);
            chk("dec_valid", {31'd0, dec_valid}, {31'd0, exp_v});
            if (exp_v && dec_valid) begin
                chk("dec_pc", {2'b00, dec_pc}, {2'b00, q[0].pc});
                chk("dec_inst", dec_inst, inst_of(q[0].pc));
            end
            if (jump_en) begin
                chk("jump_en_req", {31'd0, imem_en}, 32'd1);
                chk("jump_addr", {2'b00, imem_addr}, {2'b00, jump_target});
                q.delete();
                q.push_back('{jump_target, cyc});
                nxt = jump_target + 30'd1;
                req_cnt++;
            end else begin
                if (dec_valid && dec_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    acc_pc.push_back(dec_pc);
                    acc_cyc.push_back(cyc);
                end
                chk("imem_en", {31'd0, imem_en}, {31'd0, q.size() < DEPTH});
                if (imem_en) begin
                    chk("imem_addr", {2'b00, imem_addr}, {2'b00, nxt});
                    q.push_back('{nxt, cyc});
                    nxt = nxt + 30'd1;
                    req_cnt++;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_acc();
        acc_pc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int rel, jc, r0;
        logic [15:0] pat;
        reset = 1'b1; dec_ready = 1'b1; jump_en = 1'b0; jump_target = 30'd0;
        repeat (3) step();

        // 1: release with decode ready, stream from RESET_PC
        reset = 1'b0; rel = cyc; clear_acc();
        repeat (8) step();
        chk_acc("t1_first_pc", 0, 30'h100);
        chk_acc_cyc("t1_first_latency", 0, rel, LAT);
        chk_acc("t1_fourth_pc", 3, 30'h103);

        // 2: decode stalled for 10 cycles from a fresh start
        reset = 1'b1; step();
        reset = 1'b0; dec_ready = 1'b0; r0 = req_cnt; clear_acc();
        repeat (10) step();
        chk("t2_req_count", req_cnt - r0, 32'd4);
        chk("t2_no_accept", acc_pc.size(), 32'd0);
        dec_ready = 1'b1; clear_acc();
        repeat (14) step();
        chk_acc("t2_pop0", 0, 30'h100);
        chk_acc("t2_pop4", 4, 30'h104);
        chk_acc("t2_pop11", 11, 30'h10B);
        chk_acc_cyc("t2_seamless", 11, (acc_cyc.size() > 0) ? acc_cyc[0] : 0, 11);

        // 3: redirect with three entries buffered and one read in flight
        reset = 1'b1; step();
        reset = 1'b0; dec_ready = 1'b0;
        repeat (4) step();
        jump_en = 1'b1; jump_target = 30'h200; dec_ready = 1'b1; jc = cyc; clear_acc();
        step();
        jump_en = 1'b0;
        repeat (6) step();
        chk_acc("t3_target_pc", 0, 30'h200);
        chk_acc_cyc("t3_target_latency", 0, jc, LAT);
        chk_acc("t3_next_pc", 2, 30'h202);

        // 4: back-to-back redirects
        jump_en = 1'b1; jump_target = 30'h300; step();
        jump_target = 30'h400; jc = cyc; clear_acc(); step();
        jump_en = 1'b0;
        repeat (6) step();
        chk_acc("t4_last_target", 0, 30'h400);
        chk_acc_cyc("t4_latency", 0, jc, LAT);

        // 5: PC wraps at the top of the address space
        jump_en = 1'b1; jump_target = 30'h3FFF_FFFE; clear_acc(); step();
        jump_en = 1'b0;
        repeat (7) step();
        chk_acc("t5_top", 1, 30'h3FFF_FFFF);
        chk_acc("t5_wrap0", 2, 30'h0);
        chk_acc("t5_wrap1", 3, 30'h1);

        // 6: reset with two buffered and one in flight
        reset = 1'b1; step();
        reset = 1'b0; dec_ready = 1'b0;
        repeat (3) step();
        reset = 1'b1; step();
        reset = 1'b0; dec_ready = 1'b1; clear_acc();
        #2;
        chk("t6_valid_after_reset", {31'd0, dec_valid}, 32'd0);
        chk("t6_refetch_addr", {2'b00, imem_addr}, {2'b00, RST_PC});
        step();
        repeat (5) step();
        chk_acc("t6_first_pc", 0, 30'h100);

        // Mixed stall pattern with an occasional redirect
        pat = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 48; i++) begin
            dec_ready = pat[i % 16];
            jump_en = (i == 20) || (i == 33);
            jump_target = (i == 20) ? 30'h1234 : 30'h2_0000;
            step();
        end
        jump_en = 1'b0; dec_ready = 1'b1;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
